// File: rtl/cordic_bus_regfile.sv
// Host-facing register file for the CORDIC controller: control shadow, X/Y/Z operands,
// result snapshots and interrupt status behind a one-outstanding valid/ready bus.
module cordic_bus_regfile #(
    parameter int                 p_WIDTH      = 32,
    parameter int                 p_ADDR_WIDTH = 4,
    parameter logic [p_WIDTH-1:0] p_CTRL_RESET = 32'h0001_1FF0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [p_ADDR_WIDTH-1:0] req_addr,
    input  logic [p_WIDTH-1:0]      req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [p_WIDTH-1:0]      rsp_rdata,
    output logic                    rsp_err,
    output logic [p_WIDTH-1:0]      ctrl_reg_in,
    input  logic [p_WIDTH-1:0]      ctrl_reg_out,
    input  logic                    ctrl_wr_en,
    output logic [p_WIDTH-1:0]      x_in,
    output logic [p_WIDTH-1:0]      y_in,
    output logic [p_WIDTH-1:0]      z_in,
    input  logic [p_WIDTH-1:0]      x_res,
    input  logic [p_WIDTH-1:0]      y_res,
    input  logic [p_WIDTH-1:0]      z_res,
    output logic                    irq
);

    localparam logic [p_ADDR_WIDTH-1:0] ADDR_CTRL = p_ADDR_WIDTH'(4'd0);
    localparam logic [p_ADDR_WIDTH-1:0] ADDR_X    = p_ADDR_WIDTH'(4'd1);
    localparam logic [p_ADDR_WIDTH-1:0] ADDR_Y    = p_ADDR_WIDTH'(4'd2);
    localparam logic [p_ADDR_WIDTH-1:0] ADDR_Z    = p_ADDR_WIDTH'(4'd3);
    localparam logic [p_ADDR_WIDTH-1:0] ADDR_XR   = p_ADDR_WIDTH'(4'd4);
    localparam logic [p_ADDR_WIDTH-1:0] ADDR_YR   = p_ADDR_WIDTH'(4'd5);
    localparam logic [p_ADDR_WIDTH-1:0] ADDR_ZR   = p_ADDR_WIDTH'(4'd6);
    localparam logic [p_ADDR_WIDTH-1:0] ADDR_INT  = p_ADDR_WIDTH'(4'd7);

    logic [p_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [p_WIDTH-1:0] opnd_q [3];
    logic [p_WIDTH-1:0] opnd_d [3];
    logic [p_WIDTH-1:0] res_q  [3];
    logic [p_WIDTH-1:0] res_d  [3];
    logic [2:0]         int_q, int_d;
    logic [2:0]         int_set_s, int_clr_s;
    logic               irq_q;
    logic               rsp_valid_q, rsp_valid_d;
    logic [p_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_s, accept_s, done_s;
    logic [1:0]         opnd_idx_s, res_idx_s;

    // Write-backs stall the host, so the two update sources never meet in one cycle.
    assign busy_s    = ~ctrl_q[16];
    assign req_ready = ~(rsp_valid_q & ~rsp_ready) & ~ctrl_wr_en;
    assign accept_s  = req_valid & req_ready;
    assign done_s    = ctrl_wr_en & ctrl_reg_out[16] & ~ctrl_q[16];

    assign ctrl_reg_in = ctrl_q;
    assign x_in        = opnd_q[0];
    assign y_in        = opnd_q[1];
    assign z_in        = opnd_q[2];
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign irq         = irq_q;

    // Next-state: controller write-back, host access decode and interrupt status merge.
    always_comb begin
        ctrl_d      = ctrl_q;
        opnd_d      = opnd_q;
        res_d       = res_q;
        int_set_s   = 3'b000;
        int_clr_s   = 3'b000;
        rsp_valid_d = rsp_valid_q & ~rsp_ready;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        opnd_idx_s  = req_addr[1:0] - 2'd1;
        res_idx_s   = req_addr[1:0];
        if (ctrl_wr_en) begin
            ctrl_d = ctrl_reg_out;
            if (done_s) begin
                res_d[0]     = x_res;
                res_d[1]     = y_res;
                res_d[2]     = z_res;
                int_set_s[0] = ctrl_reg_out[5];
                int_set_s[1] = (ctrl_reg_out[17] | ctrl_reg_out[18]) & ctrl_reg_out[4];
            end else begin
                res_d = res_q;
            end
        end else if (accept_s) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
            case (req_addr)
                ADDR_CTRL: begin
                    if (!req_write) begin
                        rsp_rdata_d = ctrl_q;
                    end else if (busy_s) begin
                        rsp_err_d    = 1'b1;
                        int_set_s[2] = 1'b1;
                    end else begin
                        ctrl_d[15:0] = req_wdata[15:0];
                    end
                end
                ADDR_X, ADDR_Y, ADDR_Z: begin
                    if (!req_write) begin
                        rsp_rdata_d = opnd_q[opnd_idx_s];
                    end else if (busy_s) begin
                        rsp_err_d    = 1'b1;
                        int_set_s[2] = 1'b1;
                    end else begin
                        opnd_d[opnd_idx_s] = req_wdata;
                    end
                end
                ADDR_XR, ADDR_YR, ADDR_ZR: begin
                    if (req_write) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        rsp_rdata_d = res_q[res_idx_s];
                    end
                end
                ADDR_INT: begin
                    if (req_write) begin
                        int_clr_s = req_wdata[2:0];
                    end else begin
                        rsp_rdata_d = {{(p_WIDTH-3){1'b0}}, int_q};
                    end
                end
                default: begin
                    rsp_err_d = 1'b1;
                end
            endcase
        end else begin
            ctrl_d = ctrl_q;
        end
        // A hardware set outranks a same-cycle W1C clear.
        int_d = int_set_s | (int_q & ~int_clr_s);
    end

    // State registers; irq follows INT_STATUS one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q      <= p_CTRL_RESET;
            opnd_q      <= '{default: '0};
            res_q       <= '{default: '0};
            int_q       <= 3'b000;
            irq_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            opnd_q      <= opnd_d;
            res_q       <= res_d;
            int_q       <= int_d;
            irq_q       <= |int_q;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_cordic_bus_regfile.sv
// Directed bench for cordic_bus_regfile: table-driven bus vectors plus hand-written
// sequences for busy errors, completion snapshots, back-pressure, stalls and reset.
module tb_cordic_bus_regfile;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] ctrl_reg_in;
    logic [31:0] ctrl_reg_out;
    logic        ctrl_wr_en;
    logic [31:0] x_in, y_in, z_in;
    logic [31:0] x_res, y_res, z_res;
    logic        irq;

    int checks;
    int errors;

    cordic_bus_regfile dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ctrl_reg_in(ctrl_reg_in), .ctrl_reg_out(ctrl_reg_out), .ctrl_wr_en(ctrl_wr_en),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .x_res(x_res), .y_res(y_res), .z_res(z_res),
        .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One bus transaction; entered and left 1 time unit after a rising edge.
    task automatic xfer(input string nm, input logic w, input logic [3:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_er);
        int n;
        n = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
        #1;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got req_ready=0 expected acceptance within 20 cycles", nm);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({nm, "_vld"}, {31'd0, rsp_valid}, 32'd1);
        chk({nm, "_rdata"}, rsp_rdata, exp_rd);
        chk({nm, "_err"}, {31'd0, rsp_err}, {31'd0, exp_er});
    endtask

    task automatic wb(input logic [31:0] v, input logic [31:0] xr, input logic [31:0] yr, input logic [31:0] zr);
        ctrl_wr_en = 1'b1; ctrl_reg_out = v; x_res = xr; y_res = yr; z_res = zr;
        @(posedge clk); #1;
        ctrl_wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 4'd0; req_wdata = 32'd0;
        rsp_ready = 1'b1; ctrl_reg_out = 32'd0; ctrl_wr_en = 1'b0;
        x_res = 32'd0; y_res = 32'd0; z_res = 32'd0;

        tbl[0]  = '{1'b0, 4'd0,  32'h0,         32'h0001_1FF0, 1'b0};
        tbl[1]  = '{1'b0, 4'd4,  32'h0,         32'h0,         1'b0};
        tbl[2]  = '{1'b1, 4'd1,  32'h0000_1000, 32'h0,         1'b0};
        tbl[3]  = '{1'b1, 4'd2,  32'h0,         32'h0,         1'b0};
        tbl[4]  = '{1'b1, 4'd3,  32'h0000_2000, 32'h0,         1'b0};
        tbl[5]  = '{1'b0, 4'd1,  32'h0,         32'h0000_1000, 1'b0};
        tbl[6]  = '{1'b0, 4'd3,  32'h0,         32'h0000_2000, 1'b0};
        tbl[7]  = '{1'b1, 4'd0,  32'hFFFF_1FF5, 32'h0,         1'b0};
        tbl[8]  = '{1'b0, 4'd0,  32'h0,         32'h0001_1FF5, 1'b0};
        tbl[9]  = '{1'b1, 4'd5,  32'h0000_1234, 32'h0,         1'b1};
        tbl[10] = '{1'b0, 4'd9,  32'h0,         32'h0,         1'b1};
        tbl[11] = '{1'b1, 4'd12, 32'h0000_0055, 32'h0,         1'b1};
        tbl[12] = '{1'b0, 4'd7,  32'h0,         32'h0,         1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_ctrl", ctrl_reg_in, 32'h0001_1FF0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            xfer($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err);
        end
        chk("ctrl_in_start", ctrl_reg_in, 32'h0001_1FF5);
        chk("x_in_cfg", x_in, 32'h0000_1000);
        chk("y_in_cfg", y_in, 32'h0);
        chk("z_in_cfg", z_in, 32'h0000_2000);

        // Controller goes busy
        wb(32'h0000_1FF4, 32'd0, 32'd0, 32'd0);
        chk("ctrl_in_busy", ctrl_reg_in, 32'h0000_1FF4);
        xfer("rd_ctrl_busy", 1'b0, 4'd0, 32'h0, 32'h0000_1FF4, 1'b0);

        // Busy write errors and irq timing
        xfer("wr_x_busy", 1'b1, 4'd1, 32'h5, 32'h0, 1'b1);
        chk("x_in_kept", x_in, 32'h0000_1000);
        chk("irq_lag", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        chk("irq_busy_err", {31'd0, irq}, 32'd1);
        xfer("wr_ctrl_busy", 1'b1, 4'd0, 32'h0000_0001, 32'h0, 1'b1);
        chk("ctrl_kept", ctrl_reg_in, 32'h0000_1FF4);
        xfer("rd_int_busy", 1'b0, 4'd7, 32'h0, 32'h4, 1'b0);
        xfer("w1c_busy", 1'b1, 4'd7, 32'h4, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        xfer("rd_int_clr", 1'b0, 4'd7, 32'h0, 32'h0, 1'b0);

        // Completion snapshots and done/error status
        wb(32'h0001_1FF4, 32'h0000_ABCD, 32'h0000_0011, 32'h0000_0022);
        xfer("rd_xres", 1'b0, 4'd4, 32'h0, 32'h0000_ABCD, 1'b0);
        xfer("rd_zres", 1'b0, 4'd6, 32'h0, 32'h0000_0022, 1'b0);
        xfer("rd_int_done", 1'b0, 4'd7, 32'h0, 32'h1, 1'b0);
        xfer("w1c_done", 1'b1, 4'd7, 32'h1, 32'h0, 1'b0);
        wb(32'h0000_1FF4, 32'd0, 32'd0, 32'd0);
        wb(32'h0005_1FF4, 32'h0000_0077, 32'h0, 32'h0);
        xfer("rd_int_err", 1'b0, 4'd7, 32'h0, 32'h3, 1'b0);
        xfer("rd_xres2", 1'b0, 4'd4, 32'h0, 32'h0000_0077, 1'b0);
        wb(32'h0001_1FF0, 32'h0000_0999, 32'h0, 32'h0);
        xfer("rd_xres_nochg", 1'b0, 4'd4, 32'h0, 32'h0000_0077, 1'b0);
        xfer("rd_int_nochg", 1'b0, 4'd7, 32'h0, 32'h3, 1'b0);
        xfer("w1c_all", 1'b1, 4'd7, 32'h7, 32'h0, 1'b0);

        // Response back-pressure
        idle(1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_addr = 4'd1;
        chk("bp_vld", {31'd0, rsp_valid}, 32'd1);
        chk("bp_rdata", rsp_rdata, 32'h0001_1FF0);
        chk("bp_ready", {31'd0, req_ready}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("bp_hold_vld", {31'd0, rsp_valid}, 32'd1);
        chk("bp_hold_rdata", rsp_rdata, 32'h0001_1FF0);
        chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b_vld", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_rdata", rsp_rdata, 32'h0000_1000);

        // Write-back stalls a pending request for one cycle
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd0;
        ctrl_wr_en = 1'b1; ctrl_reg_out = 32'h0001_1FF0;
        #1;
        chk("stall_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        ctrl_wr_en = 1'b0;
        chk("stall_no_rsp", {31'd0, rsp_valid}, 32'd0);
        #1;
        chk("stall_ready_after", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("stall_vld", {31'd0, rsp_valid}, 32'd1);
        chk("stall_rdata", rsp_rdata, 32'h0001_1FF0);

        // W1C presented together with a completion: the clear waits, the set lands first
        idle(1);
        wb(32'h0000_1FF4, 32'd0, 32'd0, 32'd0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd7; req_wdata = 32'h1;
        ctrl_wr_en = 1'b1; ctrl_reg_out = 32'h0001_1FF4; x_res = 32'h0000_4242;
        #1;
        chk("race_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        ctrl_wr_en = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("race_w1c_vld", {31'd0, rsp_valid}, 32'd1);
        chk("race_w1c_err", {31'd0, rsp_err}, 32'd0);
        chk("race_irq", {31'd0, irq}, 32'd1);
        xfer("race_rd_int", 1'b0, 4'd7, 32'h0, 32'h0, 1'b0);
        xfer("race_rd_xres", 1'b0, 4'd4, 32'h0, 32'h0000_4242, 1'b0);

        // Reset mid-response
        idle(1);
        xfer("pre_rst_wr_x", 1'b1, 4'd1, 32'h0000_00AA, 32'h0, 1'b0);
        idle(1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_vld", {31'd0, rsp_valid}, 32'd1);
        chk("mid_rdata", rsp_rdata, 32'h0000_00AA);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_vld", {31'd0, rsp_valid}, 32'd0);
        chk("arst_ctrl", ctrl_reg_in, 32'h0001_1FF0);
        chk("arst_x_in", x_in, 32'h0);
        chk("arst_rdata", rsp_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        xfer("post_rst_x", 1'b0, 4'd1, 32'h0, 32'h0, 1'b0);
        xfer("post_rst_ctrl", 1'b0, 4'd0, 32'h0, 32'h0001_1FF0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cordic_bus_regfile.md
Name: cordic_bus_regfile

Overview:
Host-side register file and bus responder for the CORDIC controller. It is the bus-facing end of the controller's bus interface. It holds the control register shadow and the X/Y/Z operand registers, and presents them to the controller. It merges controller write-backs, snapshots results on completion, and raises a host interrupt.
- Host side: simple valid/ready request/response bus, one outstanding transaction.

Parameters:
p_WIDTH, 32, data/operand width
p_ADDR_WIDTH, 4, host word-address width
p_CTRL_RESET, 32'h0001_1FF0, control register reset value (Ready=1, all IntEn/StopEn=1, iterations=31)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
req_valid  in  1  host request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1=write, 0=read
req_addr  in  p_ADDR_WIDTH  word address
req_wdata  in  p_WIDTH  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_rdata  out  p_WIDTH  read data (0 for writes/errors)
rsp_err  out  1  access error
ctrl_reg_in  out  p_WIDTH  control shadow to controller
ctrl_reg_out  in  p_WIDTH  controller write-back value
ctrl_wr_en  in  1  controller write-back strobe
x_in, y_in, z_in  out  p_WIDTH each  operand registers
x_res, y_res, z_res  in  p_WIDTH each  live controller results
irq  out  1  host interrupt

Behaviour:
- Reset values:
  - ctrl shadow = p_CTRL_RESET.
  - Operand, result-snapshot and INT_STATUS registers = 0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, irq=0.
  - Reset is effective immediately; an in-flight response is dropped.
- Map (word address), any other address is unmapped:
  - 0 CTRL: RW; only bits 15:0 host-writable, 31:16 read-only flags.
  - 1/2/3 X_IN/Y_IN/Z_IN: RW.
  - 4/5/6 X_RES/Y_RES/Z_RES: RO snapshots.
  - 7 INT_STATUS: W1C; bit0 done, bit1 cordic_err, bit2 busy_err.
  - Unmapped: read 0, write ignored, rsp_err=1.
- Busy = ctrl shadow bit16 (Ready) == 0.
- Handshake:
  - req_ready = !(rsp_valid && !rsp_ready) && !ctrl_wr_en.
  - On acceptance at cycle N, rsp_valid=1 with data/err registered at N+1.
  - The response is held stable until rsp_ready. Back-to-back accept is allowed when rsp_ready=1.
  - Read data reflects register state at cycle N, before any same-cycle update.
- Host writes:
  - A write to a RO address (4-6) is ignored with rsp_err=1.
  - A write to CTRL or to X/Y/Z_IN while busy is ignored, sets INT_STATUS[2], and gives rsp_err=1.
  - A CTRL write when idle updates bits 15:0 only. Bit0 (Start) is passed to the controller through ctrl_reg_in; the controller clears it via write-back.
- Controller write-back:
  - When ctrl_wr_en=1, shadow <= ctrl_reg_out (all 32 bits) next cycle.
  - Host requests are stalled that cycle (req_ready=0), so there is never a same-cycle conflict.
- Completion:
  - Completion is a write-back with ctrl_reg_out[16]=1 while shadow[16]=0 (busy->ready).
  - On completion: X/Y/Z_RES <= x_res/y_res/z_res, and INT_STATUS[0] is set if ctrl_reg_out[5] (ResultIntEn).
  - If ctrl_reg_out[17] or [18] is set and ctrl_reg_out[4] (ErrorIntEn) is set, INT_STATUS[1] is set.
- INT_STATUS:
  - W1C clears the written bits.
  - A hardware set in the same cycle as a clear wins (bit stays 1).
- irq is registered: irq = |INT_STATUS[2:0], so it updates 1 cycle after INT_STATUS changes.
- A write-back that does not change Ready does not touch the snapshots.

Test Plan:
1. Reset, then read CTRL -> rsp_rdata=0x0001_1FF0, rsp_err=0; read X_RES -> 0; irq=0.
2. Write X_IN=0x1000, Y_IN=0, Z_IN=0x2000, then CTRL=0x0000_1FF5 -> ctrl_reg_in[15:0]=0x1FF5 and x_in=0x1000. Controller write-back 0x0000_1FF4 (Ready=0) -> CTRL reads 0x0000_1FF4.
3. While busy, write X_IN=0x5 -> x_in unchanged, rsp_err=1, INT_STATUS=0x4, irq=1 one cycle after INT_STATUS update. Then write INT_STATUS=0x4 -> irq=0.
4. Completion write-back 0x0001_1FF4 with x_res=0xABCD -> X_RES reads 0xABCD and INT_STATUS[0]=1. Same again with ctrl_reg_out[18]=1 -> INT_STATUS=0x3.
5. Hold rsp_ready=0 with req_valid=1 -> req_ready=0 and the response is stable. Assert ctrl_wr_en with a pending request -> req_ready=0 that cycle, request accepted the next cycle.
6. Read addr 9 -> rdata=0, rsp_err=1. W1C clear in the same cycle as a completion set -> INT_STATUS[0]=1. Assert rst low mid-response -> rsp_valid=0 and CTRL=0x0001_1FF0 immediately.
